// File: rtl/camera_capturemod.sv
// OV7670 capture front end: samples the sensor byte stream on PCLK strobes, packs
// two RGB565 pixels plus a 4-bit tag into one 36-bit line-buffer write.
module camera_capturemod #(
    parameter int XSIZE       = 160,
    parameter int YSIZE       = 240,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        iPclkEn,
    input  logic        iVSYNC,
    input  logic        iHREF,
    input  logic [7:0]  iData,
    output logic        oEn,
    output logic [35:0] oData,
    output logic        oLineDone,
    output logic        oFrameDone,
    output logic [8:0]  oLineCount,
    output logic        oErr
);
    localparam logic [1:0] S_SKIP   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

    localparam logic [3:0] SKIP_LAST = (SKIP_FRAMES > 0) ? 4'(SKIP_FRAMES - 1) : 4'd0;
    localparam logic [7:0] X_LAST    = 8'(XSIZE - 1);
    localparam logic [7:0] X_FULL    = 8'(XSIZE);
    localparam logic [8:0] Y_FULL    = 9'(YSIZE);

    logic [1:0]  r_state;
    logic [3:0]  r_skip;
    logic        r_vsync, r_href;
    logic        r_inline, r_ffirst, r_lfirst, r_fdpend;
    logic [1:0]  r_phase;
    logic [7:0]  r_wcnt;
    logic [15:0] r_pix0;
    logic [7:0]  r_pix1h;

    logic w_active, w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
    logic w_line_start, w_line_drop, w_close, w_byte, w_over, w_take, w_lfirst;
    logic [1:0] w_phase;
    logic [7:0] w_wcnt;

    assign w_active  = (r_state == S_ACTIVE);
    assign w_vs_rise = iPclkEn &  iVSYNC & ~r_vsync;
    assign w_vs_fall = iPclkEn & ~iVSYNC &  r_vsync;
    assign w_hr_rise = iPclkEn &  iHREF  & ~r_href;
    assign w_hr_fall = iPclkEn & ~iHREF  &  r_href;

    // A line only opens while the frame still has room; extra lines are just flagged.
    assign w_line_start = w_active & w_hr_rise & ~w_vs_rise & (oLineCount != Y_FULL);
    assign w_line_drop  = w_active & w_hr_rise & ~w_vs_rise & (oLineCount == Y_FULL);
    assign w_close      = w_active & r_inline & (w_hr_fall | w_vs_rise);

    // The strobe that raises HREF already carries the first byte of the line.
    assign w_phase  = w_line_start ? 2'd0 : r_phase;
    assign w_wcnt   = w_line_start ? 8'd0 : r_wcnt;
    assign w_lfirst = w_line_start | r_lfirst;
    assign w_byte   = w_active & iPclkEn & iHREF & ~w_vs_rise & (r_inline | w_line_start);
    assign w_over   = w_byte & (w_wcnt == X_FULL);
    assign w_take   = w_byte & ~w_over;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= S_SKIP;
            r_skip     <= 4'd0;
            r_vsync    <= 1'b0;
            r_href     <= 1'b0;
            r_inline   <= 1'b0;
            r_ffirst   <= 1'b0;
            r_lfirst   <= 1'b0;
            r_fdpend   <= 1'b0;
            r_phase    <= 2'd0;
            r_wcnt     <= 8'd0;
            r_pix0     <= 16'd0;
            r_pix1h    <= 8'd0;
            oEn        <= 1'b0;
            oData      <= 36'd0;
            oLineDone  <= 1'b0;
            oFrameDone <= 1'b0;
            oLineCount <= 9'd0;
            oErr       <= 1'b0;
        end else begin
            oEn        <= 1'b0;
            oLineDone  <= 1'b0;
            oFrameDone <= r_fdpend;
            r_fdpend   <= 1'b0;
            if (iPclkEn) begin
                r_vsync <= iVSYNC;
                r_href  <= iHREF;
            end

            case (r_state)
                S_SKIP: begin
                    if (SKIP_FRAMES == 0) begin
                        r_state <= S_WAIT;
                    end else if (w_vs_rise) begin
                        if (r_skip == SKIP_LAST) r_state <= S_WAIT;
                        r_skip <= r_skip + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (w_vs_fall) begin
                        r_state    <= S_ACTIVE;
                        oLineCount <= 9'd0;
                        r_wcnt     <= 8'd0;
                        r_ffirst   <= 1'b1;
                        r_inline   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    // An open line closes this cycle, so the frame pulse waits one cycle.
                    if (w_vs_rise) begin
                        r_state <= S_WAIT;
                        if (w_close) r_fdpend   <= 1'b1;
                        else         oFrameDone <= 1'b1;
                    end
                end
                default: r_state <= S_SKIP;
            endcase

            if (w_line_drop) oErr <= 1'b1;
            if (w_over)      oErr <= 1'b1;

            if (w_line_start) begin
                r_inline <= 1'b1;
                r_wcnt   <= 8'd0;
                r_lfirst <= 1'b1;
                r_phase  <= 2'd0;
            end

            if (w_close) begin
                r_inline   <= 1'b0;
                oLineDone  <= 1'b1;
                oLineCount <= oLineCount + 9'd1;
                if (w_wcnt < X_FULL) oErr <= 1'b1;
            end

            if (w_take) begin
                r_phase <= w_phase + 2'd1;
                case (w_phase)
                    2'd0: r_pix0[15:8] <= iData;
                    2'd1: r_pix0[7:0]  <= iData;
                    2'd2: r_pix1h      <= iData;
                    default: begin
                        oEn      <= 1'b1;
                        oData    <= {r_ffirst, w_lfirst, (w_wcnt == X_LAST), 1'b0,
                                     r_pix0, r_pix1h, iData};
                        r_wcnt   <= w_wcnt + 8'd1;
                        r_ffirst <= 1'b0;
                        r_lfirst <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_camera_capturemod.sv
// Random-stimulus bench for camera_capturemod: a frame/line level model predicts the
// packed words, pulses, line count and error flag for each scenario.
module tb_camera_capturemod;
    localparam int XS = 160;
    localparam int YS = 4;
    localparam int SK = 2;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        iPclkEn = 1'b0, iVSYNC = 1'b0, iHREF = 1'b0;
    logic [7:0]  iData = 8'd0;
    logic        oEn, oLineDone, oFrameDone, oErr;
    logic [35:0] oData;
    logic [8:0]  oLineCount;

    camera_capturemod #(.XSIZE(XS), .YSIZE(YS), .SKIP_FRAMES(SK)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .iPclkEn(iPclkEn), .iVSYNC(iVSYNC),
        .iHREF(iHREF), .iData(iData), .oEn(oEn), .oData(oData),
        .oLineDone(oLineDone), .oFrameDone(oFrameDone),
        .oLineCount(oLineCount), .oErr(oErr)
    );

    always #5 CLOCK = ~CLOCK;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor
    logic [35:0] got_q[$];
    int n_ld = 0, n_fd = 0, n_b2b = 0;
    logic prev_en = 1'b0;
    always @(negedge CLOCK) begin
        if (oEn === 1'b1) got_q.push_back(oData);
        if (oLineDone === 1'b1) n_ld++;
        if (oFrameDone === 1'b1) n_fd++;
        if (oEn === 1'b1 && prev_en === 1'b1) n_b2b++;
        prev_en = oEn;
    end

    // Reference model: frame/line bookkeeping from the sensor timing rules
    logic [35:0] exp_q[$];
    int m_skip, m_line, m_ld = 0, m_fd = 0;
    bit m_cap, m_ff, m_err;
    int gap_lo = 1, gap_hi = 2;
    logic [7:0] pre[4];
    int pre_n = 0;

    task automatic m_reset();
        m_skip = SK; m_cap = 0; m_err = 0; m_line = 0; m_ff = 0;
    endtask

    function automatic bit m_vrise();
        bit fd = m_cap;
        if (m_cap) begin m_cap = 0; m_fd++; end
        else if (m_skip > 0) m_skip--;
        return fd;
    endfunction

    function automatic void m_vfall();
        if (!m_cap && m_skip == 0) begin m_cap = 1; m_line = 0; m_ff = 1; end
    endfunction

    task automatic strobe(input bit vs, input bit hr, input logic [7:0] d);
        int g = int'($urandom_range(gap_hi, gap_lo));
        for (int i = 1; i < g; i++) begin
            iPclkEn = 1'b0; iVSYNC = 1'($urandom); iHREF = 1'($urandom); iData = 8'($urandom);
            @(posedge CLOCK); #1;
        end
        iPclkEn = 1'b1; iVSYNC = vs; iHREF = hr; iData = d;
        @(posedge CLOCK); #1;
        iPclkEn = 1'b0;
    endtask

    task automatic vs_tail();
        strobe(1, 0, 8'($urandom));
        strobe(1, 0, 8'($urandom));
        strobe(0, 0, 8'($urandom));
        m_vfall();
        strobe(0, 0, 8'($urandom));
        strobe(0, 0, 8'($urandom));
    endtask

    task automatic vs_pulse();
        bit fd;
        strobe(1, 0, 8'($urandom));
        fd = m_vrise();
        chk("fdone", 64'(oFrameDone), 64'(fd));
        vs_tail();
    endtask

    task automatic send_line(input int n, input bit vs_end);
        bit cap, fd;
        logic [7:0] b[4];
        logic [7:0] d;
        logic [3:0] tag;
        cap = m_cap && (m_line < YS);
        if (m_cap && !cap) m_err = 1;
        for (int i = 0; i < n; i++) begin
            d = (i < pre_n) ? pre[i] : 8'($urandom);
            b[i % 4] = d;
            strobe(0, 1, d);
            if (cap && (i % 4 == 3) && (i / 4 < XS)) begin
                tag = {m_ff, (i / 4 == 0), (i / 4 == XS - 1), 1'b0};
                m_ff = 0;
                exp_q.push_back({tag, b[0], b[1], b[2], b[3]});
                chk("en_word", 64'(oEn), 64'(1));
            end else begin
                chk("en_idle", 64'(oEn), 64'(0));
            end
            if (cap && i >= 4 * XS) m_err = 1;
            chk("err_byte", 64'(oErr), 64'(m_err));
        end
        if (vs_end) strobe(1, 1, 8'($urandom));
        else        strobe(0, 0, 8'($urandom));
        chk("ldone", 64'(oLineDone), 64'(cap));
        if (cap) begin
            m_line++; m_ld++;
            if (n < 4 * XS) m_err = 1;
        end
        chk("lcnt", 64'(oLineCount), 64'(m_line));
        chk("err_eol", 64'(oErr), 64'(m_err));
        if (vs_end) begin
            fd = m_vrise();
            chk("fdone_early", 64'(oFrameDone), 64'(fd && !cap));
            @(posedge CLOCK); #1;
            chk("fdone_late", 64'(oFrameDone), 64'(fd && cap));
            vs_tail();
        end else begin
            strobe(0, 0, 8'($urandom));
            strobe(0, 0, 8'($urandom));
        end
    endtask

    task automatic sb_check(input string tag);
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_word"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
        chk({tag, "_nldone"}, 64'(n_ld), 64'(m_ld));
        chk({tag, "_nfdone"}, 64'(n_fd), 64'(m_fd));
    endtask

    task automatic do_reset();
        iPclkEn = 1'b0; iVSYNC = 1'b0; iHREF = 1'b0;
        RESET = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        m_reset();
    endtask

    task automatic skip_frames();
        for (int f = 0; f < SK; f++) vs_pulse();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge CLOCK);
        #1;
        chk("rst_en", 64'(oEn), 64'(0));
        chk("rst_data", 64'(oData), 64'(0));
        chk("rst_ldone", 64'(oLineDone), 64'(0));
        chk("rst_fdone", 64'(oFrameDone), 64'(0));
        chk("rst_lcnt", 64'(oLineCount), 64'(0));
        chk("rst_err", 64'(oErr), 64'(0));
        RESET = 1'b0;
        m_reset();

        // Two settling frames then one captured frame; first word has a fixed pattern
        for (int f = 0; f < SK; f++) begin
            send_line(4 * XS, 0);
            vs_pulse();
        end
        pre[0] = 8'h12; pre[1] = 8'h34; pre[2] = 8'h56; pre[3] = 8'h78; pre_n = 4;
        for (int l = 0; l < YS; l++) send_line(4 * XS, 0);
        pre_n = 0;
        vs_pulse();
        chk("pack_first", 64'(got_q.size() > 0 ? got_q[0] : 36'h0), 64'(36'hC_1234_5678));
        chk("pack_last_tag", 64'(got_q.size() > XS - 1 ? got_q[XS - 1][35:32] : 4'hF), 64'(4'b0010));
        chk("full_err", 64'(oErr), 64'(0));
        sb_check("full");

        // Overlong line
        do_reset(); skip_frames();
        send_line(4 * XS + 4, 0);
        send_line(4 * XS, 0);
        vs_pulse();
        sb_check("long");

        // Short, odd line
        do_reset(); skip_frames();
        send_line(7, 0);
        vs_pulse();
        sb_check("short");

        // Lines beyond the frame height
        do_reset(); skip_frames();
        for (int l = 0; l < YS; l++) send_line(4 * XS, 0);
        chk("extra_err_pre", 64'(oErr), 64'(0));
        send_line(8, 0);
        vs_pulse();
        sb_check("extra");

        // Sparse strobes with junk between, then a line cut by VSYNC
        do_reset(); skip_frames();
        gap_lo = 3; gap_hi = 3;
        send_line(4 * XS, 0);
        chk("gap_err", 64'(oErr), 64'(0));
        gap_lo = 1; gap_hi = 2;
        send_line(100, 1);
        sb_check("gap_vs");

        // Reset in the middle of a word
        do_reset(); skip_frames();
        for (int i = 0; i < 6; i++) strobe(0, 1, 8'(i + 1));
        exp_q.push_back({4'hC, 8'h01, 8'h02, 8'h03, 8'h04});
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        chk("mr_en", 64'(oEn), 64'(0));
        chk("mr_data", 64'(oData), 64'(0));
        chk("mr_ldone", 64'(oLineDone), 64'(0));
        chk("mr_fdone", 64'(oFrameDone), 64'(0));
        chk("mr_lcnt", 64'(oLineCount), 64'(0));
        chk("mr_err", 64'(oErr), 64'(0));
        RESET = 1'b0;
        m_reset();
        send_line(10, 0);
        for (int f = 0; f < SK; f++) begin
            send_line(8, 0);
            vs_pulse();
        end
        send_line(4 * XS, 0);
        vs_pulse();
        sb_check("midrst");

        chk("en_b2b", 64'(n_b2b), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
